// File: rtl/nbody_pkg.sv
// Shared types and defaults for the N-body pair scheduler.
//   fp64_t        : raw IEEE-754 double bit pattern
//   body_t        : one body record {x, y, m}
//   pair_tag_t    : per-cycle tag {valid, idx, last} carried alongside pairs
//   sched_state_e : scheduler FSM states
package nbody_pkg;

  localparam int unsigned IDX_W        = 10;
  localparam int unsigned PIPE_LATENCY = 122;

  typedef logic [63:0] fp64_t;

  typedef struct packed {
    fp64_t x;
    fp64_t y;
    fp64_t m;
  } body_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             last;
  } pair_tag_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_I,
    S_STREAM,
    S_DRAIN,
    S_FLUSH
  } sched_state_e;

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register for tag payloads.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (clears every stage)
//   din      : value entering the line this cycle
//   dout     : value that entered DEPTH cycles ago (registered)
module tag_delay_line #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  T     din,
  output T     dout
);

  T stages [DEPTH];

  // Plain shift; reset is the only way to clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stages[k] <= '0;
    end else begin
      stages[0] <= din;
      for (int k = 1; k < DEPTH; k++) stages[k] <= stages[k-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/body_pair_scheduler.sv
// Pair scheduler feeding the pairwise gravity-acceleration pipeline.
// Walks every ordered pair (i,j), j != i, reading bodies from RAM, and emits a
// tag stream delayed by PipeLatency so it lines up with the pipeline output.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, n_bodies     : sweep request and body count (sampled in IDLE)
//   busy, done          : sweep in progress / 1-cycle completion pulse
//   rd_addr, rd_x/y/m   : body RAM read port (fixed MemLatency)
//   x1, y1              : position of body i
//   x2, y2, m2          : position and mass of body j
//   pair_valid          : x1..m2 hold a real pair this cycle
//   acc_valid/idx/last  : tag aligned with the pipeline output
// Optional macro SCHED_STATS_EN adds pair_count and sweep_cycles outputs.
module body_pair_scheduler
  import nbody_pkg::*;
#(
  parameter int unsigned IdxW        = IDX_W,
  parameter int unsigned MemLatency  = 2,
  parameter int unsigned PipeLatency = PIPE_LATENCY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IdxW:0]   n_bodies,
  output logic            busy,
  output logic            done,
  output logic [IdxW-1:0] rd_addr,
  input  fp64_t           rd_x,
  input  fp64_t           rd_y,
  input  fp64_t           rd_m,
  output fp64_t           x1,
  output fp64_t           y1,
  output fp64_t           x2,
  output fp64_t           y2,
  output fp64_t           m2,
  output logic            pair_valid,
  output logic            acc_valid,
  output logic [IdxW-1:0] acc_idx,
  output logic            acc_last
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]     pair_count,
  output logic [31:0]     sweep_cycles
`endif
);

  localparam int unsigned IW1       = IdxW + 1;
  localparam int unsigned CntMax    = (PipeLatency > MemLatency) ? PipeLatency : MemLatency;
  localparam int unsigned CntW      = $clog2(CntMax + 1);
  localparam logic [IdxW:0] MaxBodies = IW1'(1) << IdxW;

  sched_state_e    state;
  logic [IdxW:0]   n_q, i_q, j_q;
  logic [CntW-1:0] cnt;
  pair_tag_t       rd_tag_q, shadow_out, pair_tag_q, acc_tag;
  body_t           rd_body, pj_q;

  logic [IdxW:0] last_j_c, j_first_c, j_next_c, i_next_c, n_clamp_c;

  // Index arithmetic: first/next j skipping i, last j of the current row.
  always_comb begin
    last_j_c  = (i_q == n_q - IW1'(1)) ? n_q - IW1'(2) : n_q - IW1'(1);
    j_first_c = (i_q == '0) ? IW1'(1) : '0;
    j_next_c  = (j_q + IW1'(1) == i_q) ? j_q + IW1'(2) : j_q + IW1'(1);
    i_next_c  = i_q + IW1'(1);
    n_clamp_c = (n_bodies > MaxBodies) ? MaxBodies : n_bodies;
  end

  // Sweep control; rd_tag_q travels with rd_addr into the read shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_addr  <= '0;
      x1       <= '0;
      y1       <= '0;
      n_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      cnt      <= '0;
      rd_tag_q <= '0;
    end else begin
      done     <= 1'b0;
      rd_tag_q <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n_q  <= n_clamp_c;
            i_q  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
            if (n_clamp_c <= IW1'(1)) begin
              state <= S_FLUSH;
            end else begin
              rd_addr <= '0;
              state   <= S_FETCH_I;
            end
          end
        end
        S_FETCH_I: begin
          if (cnt == CntW'(MemLatency)) begin
            x1       <= rd_x;
            y1       <= rd_y;
            cnt      <= '0;
            j_q      <= j_first_c;
            rd_addr  <= j_first_c[IdxW-1:0];
            rd_tag_q <= '{valid: 1'b1, idx: IDX_W'(i_q), last: (j_first_c == last_j_c)};
            state    <= S_STREAM;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        S_STREAM: begin
          if (rd_tag_q.last) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else begin
            j_q      <= j_next_c;
            rd_addr  <= j_next_c[IdxW-1:0];
            rd_tag_q <= '{valid: 1'b1, idx: IDX_W'(i_q), last: (j_next_c == last_j_c)};
          end
        end
        S_DRAIN: begin
          // Fixed read latency: shadow is empty MemLatency+1 cycles after the last read.
          if (cnt == CntW'(MemLatency)) begin
            cnt <= '0;
            i_q <= i_next_c;
            if (i_next_c == n_q) begin
              state <= S_FLUSH;
            end else begin
              rd_addr <= i_next_c[IdxW-1:0];
              state   <= S_FETCH_I;
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        S_FLUSH: begin
          if (cnt == CntW'(PipeLatency - 1)) begin
            cnt   <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  tag_delay_line #(.T(pair_tag_t), .DEPTH(MemLatency)) u_read_shadow (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_tag_q),
    .dout (shadow_out)
  );

  assign rd_body = '{x: rd_x, y: rd_y, m: rd_m};

  // Register returning body j; bubbles hold the data and push an empty tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_tag_q <= '0;
      pj_q       <= '0;
    end else begin
      pair_tag_q <= shadow_out.valid ? shadow_out : '0;
      if (shadow_out.valid) pj_q <= rd_body;
    end
  end

  assign x2         = pj_q.x;
  assign y2         = pj_q.y;
  assign m2         = pj_q.m;
  assign pair_valid = pair_tag_q.valid;

  tag_delay_line #(.T(pair_tag_t), .DEPTH(PipeLatency)) u_tag_line (
    .clk  (clk),
    .rst  (rst),
    .din  (pair_tag_q),
    .dout (acc_tag)
  );

  assign acc_valid = acc_tag.valid;
  assign acc_idx   = IdxW'(acc_tag.idx);
  assign acc_last  = acc_tag.last;

`ifdef SCHED_STATS_EN
  // Saturating per-sweep statistics, cleared on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_count   <= '0;
      sweep_cycles <= '0;
    end else if (state == S_IDLE && start) begin
      pair_count   <= '0;
      sweep_cycles <= '0;
    end else begin
      if (pair_valid && pair_count != '1) pair_count <= pair_count + 32'd1;
      if (busy && sweep_cycles != '1) sweep_cycles <= sweep_cycles + 32'd1;
    end
  end
`endif

endmodule
